seq_scan_ctrl: RTL and testbench

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

---
 rtl/seq_scan_pkg.sv | 16 +
 rtl/bit_cnt.sv | 41 ++++
 rtl/seq_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seq_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// Shared constants and state encoding for the byte scan sequencer.
package seq_scan_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT   = 8;
    localparam int unsigned BIT_IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/bit_cnt.sv
// 3-bit down counter with load and enable; zero flag tracks the registered count.
module bit_cnt
    import seq_scan_pkg::*;
(
    input  logic                 clk,
    input  logic                 rnt,
    input  logic                 load_i,
    input  logic [BIT_IDX_W-1:0] load_val_i,
    input  logic                 en_i,
    output logic [BIT_IDX_W-1:0] cnt_o,
    output logic                 zero_o
);

    logic [BIT_IDX_W-1:0] cnt_q, cnt_d;
    logic                 zero_q, zero_d;

    // Holds at zero rather than wrapping so a late enable cannot restart the count.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !zero_q) begin
            cnt_d = cnt_q - BIT_IDX_W'(1);
        end
        zero_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rnt) begin
        if (!rnt) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = zero_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Sequences an external parallel-to-serial shifter and sequence detector, one byte
// at a time, and accumulates detector hits.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter bit          CLR_PER_BYTE = 1'b1
) (
    input  logic              clk,
    input  logic              rnt,
    input  logic              clr,
    input  logic [BYTE_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [BYTE_W-1:0] ser_data,
    output logic              ser_load,
    output logic              ser_en,
    output logic              det_clr,
    input  logic              det_hit,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic              hit_flag
);

    state_e               state_q, state_d;
    logic [BYTE_W-1:0]    ser_data_q, ser_data_d;
    logic                 ser_load_q, ser_load_d;
    logic                 ser_en_q, ser_en_d;
    logic                 det_clr_q, det_clr_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic                 hit_flag_q, hit_flag_d;

    logic                 cnt_load, cnt_en, bit_zero, hit_win;
    logic [BIT_IDX_W-1:0] bit_idx;

    assign cnt_load = (state_q == ST_LOAD);
    assign cnt_en   = (state_q == ST_SHIFT);

    bit_cnt u_bit_cnt (
        .clk        (clk),
        .rnt        (rnt),
        .load_i     (cnt_load),
        .load_val_i (BIT_IDX_W'(BIT_CNT - 1)),
        .en_i       (cnt_en),
        .cnt_o      (bit_idx),
        .zero_o     (bit_zero)
    );

    // Detector output lags the bit by one cycle: skip the first shift, include flush.
    assign hit_win = ((state_q == ST_SHIFT) && (bit_idx != BIT_IDX_W'(BIT_CNT - 1)))
                   || (state_q == ST_FLUSH);

    always_comb begin
        state_d    = state_q;
        ser_data_d = ser_data_q;
        hit_cnt_d  = hit_cnt_q;
        hit_flag_d = hit_flag_q;

        unique case (state_q)
            ST_IDLE: begin
                if (din_valid) begin
                    state_d    = ST_LOAD;
                    ser_data_d = din;
                end
            end
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (bit_zero) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (hit_win && det_hit) begin
            hit_flag_d = 1'b1;
            if (hit_cnt_q != '1) begin
                hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end
        end

        // Clear wins over everything, including a handshake in the same cycle.
        if (clr) begin
            state_d    = ST_IDLE;
            ser_data_d = ser_data_q;
            hit_cnt_d  = '0;
            hit_flag_d = 1'b0;
        end

        ser_load_d = (state_d == ST_LOAD);
        ser_en_d   = (state_d == ST_SHIFT);
        done_d     = (state_d == ST_DONE);
        det_clr_d  = clr || (CLR_PER_BYTE && (state_d == ST_LOAD));
    end

    always_ff @(posedge clk or negedge rnt) begin
        if (!rnt) begin
            state_q    <= ST_IDLE;
            ser_data_q <= '0;
            ser_load_q <= 1'b0;
            ser_en_q   <= 1'b0;
            det_clr_q  <= 1'b0;
            done_q     <= 1'b0;
            hit_cnt_q  <= '0;
            hit_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ser_data_q <= ser_data_d;
            ser_load_q <= ser_load_d;
            ser_en_q   <= ser_en_d;
            det_clr_q  <= det_clr_d;
            done_q     <= done_d;
            hit_cnt_q  <= hit_cnt_d;
            hit_flag_q <= hit_flag_d;
        end
    end

    assign din_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign ser_data  = ser_data_q;
    assign ser_load  = ser_load_q;
    assign ser_en    = ser_en_q;
    assign det_clr   = det_clr_q;
    assign done      = done_q;
    assign hit_cnt   = hit_cnt_q;
    assign hit_flag  = hit_flag_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl with a shifter model and an overlapping 1101 detector model.
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rnt = 1'b0;
    logic       clr = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din = 8'h00;

    logic       din_ready, ser_load, ser_en, det_clr, busy, done, hit_flag;
    logic [7:0] ser_data, hit_cnt;
    logic       din_ready2, ser_load2, ser_en2, det_clr2, busy2, done2, hit_flag2;
    logic [7:0] ser_data2;
    logic [1:0] hit_cnt2;

    logic       det_hit;
    logic [7:0] sh_q;
    logic [3:0] hist_q;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.CNT_W(8), .CLR_PER_BYTE(1'b1)) dut (
        .clk(clk), .rnt(rnt), .clr(clr), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .ser_data(ser_data), .ser_load(ser_load),
        .ser_en(ser_en), .det_clr(det_clr), .det_hit(det_hit), .busy(busy),
        .done(done), .hit_cnt(hit_cnt), .hit_flag(hit_flag)
    );

    seq_scan_ctrl #(.CNT_W(2), .CLR_PER_BYTE(1'b1)) dut_sat (
        .clk(clk), .rnt(rnt), .clr(clr), .din(din), .din_valid(din_valid),
        .din_ready(din_ready2), .ser_data(ser_data2), .ser_load(ser_load2),
        .ser_en(ser_en2), .det_clr(det_clr2), .det_hit(det_hit), .busy(busy2),
        .done(done2), .hit_cnt(hit_cnt2), .hit_flag(hit_flag2)
    );

    // External shifter (MSB first) and 1101 detector with registered hit output.
    always_ff @(posedge clk or negedge rnt) begin
        if (!rnt) begin
            sh_q    <= 8'h00;
            hist_q  <= 4'h0;
            det_hit <= 1'b0;
        end else begin
            if (ser_load)    sh_q <= ser_data;
            else if (ser_en) sh_q <= {sh_q[6:0], 1'b0};
            if (det_clr) begin
                hist_q  <= 4'h0;
                det_hit <= 1'b0;
            end else if (ser_en) begin
                hist_q  <= {hist_q[2:0], sh_q[7]};
                det_hit <= ({hist_q[2:0], sh_q[7]} == 4'b1101);
            end else begin
                det_hit <= 1'b0;
            end
        end
    end

    task automatic test_reset();
        rnt = 1'b0; clr = 1'b0; din_valid = 1'b0; din = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({din_ready, busy, ser_load, ser_en, det_clr, done, hit_flag} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 1000000",
                     {din_ready, busy, ser_load, ser_en, det_clr, done, hit_flag});
        end
        checks++;
        if (ser_data !== 8'h00 || hit_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: ser_data=%h hit_cnt=%0d want 00/0", ser_data, hit_cnt);
        end
        checks++;
        if ({din_ready2, busy2, ser_load2, ser_en2, det_clr2, done2, hit_flag2} !== 7'b1000000
            || ser_data2 !== 8'h00 || hit_cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_sat: got ctl=%b data=%h cnt=%0d want 1000000/00/0",
                     {din_ready2, busy2, ser_load2, ser_en2, det_clr2, done2, hit_flag2},
                     ser_data2, hit_cnt2);
        end
        rnt = 1'b1;
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b want 1/0", din_ready, busy);
        end
    endtask

    // Starts at a negedge in IDLE; ends at the negedge after DONE, back in IDLE.
    task automatic do_frame(input logic [7:0] b, input logic [7:0] exp_cnt, input string tag);
        int en_cnt, en_first, en_last, done_cyc, done_cnt;
        din = b; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        checks++;
        if ({ser_load, det_clr, busy, din_ready} !== 4'b1110 || ser_data !== b) begin
            errors++;
            $display("FAIL %s_load: load/clr/busy/ready=%b data=%h want 1110/%h",
                     tag, {ser_load, det_clr, busy, din_ready}, ser_data, b);
        end
        en_cnt = 0; en_first = 0; en_last = 0; done_cyc = 0; done_cnt = 0;
        for (int k = 2; k <= 13; k++) begin
            @(negedge clk);
            if (ser_en) begin
                en_cnt++;
                if (en_first == 0) en_first = k;
                en_last = k;
            end
            if (done) begin
                done_cnt++;
                done_cyc = k;
            end
        end
        checks++;
        if (en_cnt != 8 || en_first != 2 || en_last != 9) begin
            errors++;
            $display("FAIL %s_shift: en_cnt=%0d first=%0d last=%0d want 8/2/9",
                     tag, en_cnt, en_first, en_last);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 11) begin
            errors++;
            $display("FAIL %s_done: pulses=%0d at cycle %0d want 1 at 11", tag, done_cnt, done_cyc);
        end
        checks++;
        if (din_ready !== 1'b1 || busy !== 1'b0 || ser_data !== b) begin
            errors++;
            $display("FAIL %s_idle: ready=%b busy=%b data=%h want 1/0/%h",
                     tag, din_ready, busy, ser_data, b);
        end
        checks++;
        if (hit_cnt !== exp_cnt || hit_flag !== (exp_cnt != 8'd0)) begin
            errors++;
            $display("FAIL %s_hits: cnt=%0d flag=%b want %0d/%b",
                     tag, hit_cnt, hit_flag, exp_cnt, (exp_cnt != 8'd0));
        end
    endtask

    task automatic test_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (det_clr !== 1'b1 || hit_cnt !== 8'd0 || hit_flag !== 1'b0 || hit_cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL clr: det_clr=%b cnt=%0d flag=%b cnt_sat=%0d want 1/0/0/0",
                     det_clr, hit_cnt, hit_flag, hit_cnt2);
        end
    endtask

    task automatic test_back_to_back();
        int low_cnt, done_cnt;
        din = 8'hDA; din_valid = 1'b1;
        @(negedge clk);
        low_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (din_ready) break;
            low_cnt++;
            @(negedge clk);
        end
        checks++;
        if (low_cnt != 11) begin
            errors++;
            $display("FAIL b2b_gap: ready low %0d cycles want 11", low_cnt);
        end
        @(negedge clk);
        din_valid = 1'b0;
        checks++;
        if (ser_load !== 1'b1 || ser_data !== 8'hDA) begin
            errors++;
            $display("FAIL b2b_second_load: load=%b data=%h want 1/da", ser_load, ser_data);
        end
        done_cnt = 0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checks++;
        if (done_cnt != 1 || hit_cnt !== 8'd4 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end: dones=%0d cnt=%0d ready=%b want 1/4/1", done_cnt, hit_cnt, din_ready);
        end
    endtask

    task automatic test_clr_abort();
        int done_cnt, busy_cnt;
        din = 8'hDA; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (ser_en !== 1'b1 || busy !== 1'b1 || hit_cnt !== 8'd4) begin
            errors++;
            $display("FAIL abort_pre: ser_en=%b busy=%b cnt=%0d want 1/1/4", ser_en, busy, hit_cnt);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if ({busy, din_ready, det_clr, ser_en, ser_load, hit_flag} !== 6'b011000 || hit_cnt !== 8'd0) begin
            errors++;
            $display("FAIL abort_clr: busy/ready/dclr/en/load/flag=%b cnt=%0d want 011000/0",
                     {busy, din_ready, det_clr, ser_en, ser_load, hit_flag}, hit_cnt);
        end
        done_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        checks++;
        if (done_cnt != 0 || busy_cnt != 0 || hit_cnt !== 8'd0) begin
            errors++;
            $display("FAIL abort_after: dones=%0d busy_cycles=%0d cnt=%0d want 0/0/0",
                     done_cnt, busy_cnt, hit_cnt);
        end
    endtask

    task automatic test_reset_mid();
        din = 8'hDA; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (ser_en !== 1'b1 || hit_cnt !== 8'd1) begin
            errors++;
            $display("FAIL midrst_pre: ser_en=%b cnt=%0d want 1/1", ser_en, hit_cnt);
        end
        rnt = 1'b0;
        #1;
        checks++;
        if ({din_ready, busy, ser_load, ser_en, det_clr, done, hit_flag} !== 7'b1000000
            || ser_data !== 8'h00 || hit_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midrst_async: ctl=%b data=%h cnt=%0d want 1000000/00/0",
                     {din_ready, busy, ser_load, ser_en, det_clr, done, hit_flag}, ser_data, hit_cnt);
        end
        @(negedge clk);
        rnt = 1'b1;
        do_frame(8'hDA, 8'd2, "after_rst");
    endtask

    task automatic test_saturate();
        logic [1:0] exp_sat [3];
        logic [7:0] exp_full [3];
        exp_sat[0] = 2'd2; exp_sat[1] = 2'd3; exp_sat[2] = 2'd3;
        exp_full[0] = 8'd2; exp_full[1] = 8'd4; exp_full[2] = 8'd6;
        test_clr();
        for (int f = 0; f < 3; f++) begin
            do_frame(8'hDA, exp_full[f], "sat_frame");
            checks++;
            if (hit_cnt2 !== exp_sat[f] || hit_flag2 !== 1'b1) begin
                errors++;
                $display("FAIL sat_cnt%0d: cnt=%0d flag=%b want %0d/1", f, hit_cnt2, hit_flag2, exp_sat[f]);
            end
        end
    endtask

    initial begin
        test_reset();
        do_frame(8'hDA, 8'd2, "frame_da");
        test_clr();
        do_frame(8'h00, 8'd0, "frame_00");
        test_back_to_back();
        test_clr_abort();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
